// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, capture FSM state type and the 9-bit-per-pixel CRC step
// used by the capture receiver.
package vga_timing_pkg;

    localparam int RGB_W = 9;
    localparam int CNT_W = 10;

    // 640x480 @ 800x525 mode; H_BACK/V_BACK count from the sync assert edge
    localparam int H_TOTAL_DEF  = 800;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_FRONT_DEF  = 16;
    localparam int H_BACK_DEF   = 144;
    localparam int V_TOTAL_DEF  = 525;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_FRONT_DEF  = 10;
    localparam int V_BACK_DEF   = 35;

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } cap_state_e;

    // CRC-16-CCITT (poly 0x1021), one pixel of RGB_W bits, MSB first
    function automatic logic [15:0] crc16_step_pix(input logic [15:0] crc_in,
                                                   input logic [RGB_W-1:0] data);
        logic [15:0] crc;
        logic        fb;
        crc = crc_in;
        for (int i = RGB_W - 1; i >= 0; i--) begin
            fb  = crc[15] ^ data[i];
            crc = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return crc;
    endfunction

endpackage

// File: rtl/vga_capture_receiver_sync_edge.sv
// Input register, polarity normalisation and assert-edge pulse for one sync line.
module vga_sync_edge_detect #(
    parameter bit SYNC_POL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic sync_in,
    output logic assert_edge
);

    logic asserted_q, asserted_d;
    logic prev_q, prev_d;

    always_comb begin
        asserted_d = (sync_in == SYNC_POL);
        prev_d     = asserted_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            asserted_q <= 1'b0;
            prev_q     <= 1'b0;
        end else begin
            asserted_q <= asserted_d;
            prev_q     <= prev_d;
        end
    end

    assign assert_edge = asserted_q & ~prev_q;

endmodule

// File: rtl/vga_capture_receiver.sv
// VGA sink: recovers line/frame position, locks to the configured mode and emits a pixel stream.
// Define VGA_CAPTURE_CRC_EN to add a per-frame CRC-16-CCITT of the captured pixels.
module vga_capture_receiver
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL     = H_TOTAL_DEF,
    parameter int V_TOTAL     = V_TOTAL_DEF,
    parameter int H_BACK      = H_BACK_DEF,
    parameter int V_BACK      = V_BACK_DEF,
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter bit SYNC_POL    = 1'b0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             vgaHsync,
    input  logic             vgaVsync,
    input  logic [RGB_W-1:0] vgaRGB,
    output logic             pixValid,
    output logic [9:0]       pixX,
    output logic [8:0]       pixY,
    output logic [RGB_W-1:0] pixData,
    output logic             frameStart,
    output logic             locked,
    output logic             lockErr
`ifdef VGA_CAPTURE_CRC_EN
    ,
    output logic [15:0]      frameCrc,
    output logic             crcValid
`endif
);

    localparam logic [10:0] H_TOTAL_L = 11'(H_TOTAL);
    localparam logic [10:0] V_TOTAL_L = 11'(V_TOTAL);
    localparam logic [10:0] H_BEG_L   = 11'(H_BACK);
    localparam logic [10:0] H_END_L   = 11'(H_BACK + H_ACTIVE);
    localparam logic [10:0] V_BEG_L   = 11'(V_BACK);
    localparam logic [10:0] V_END_L   = 11'(V_BACK + V_ACTIVE);
    localparam logic [9:0]  H_OFS     = 10'(H_BACK);
    localparam logic [8:0]  V_OFS     = 9'(V_BACK);
    localparam logic [2:0]  LOCK_L    = 3'(LOCK_FRAMES);

    logic h_edge, v_edge;

    vga_sync_edge_detect #(.SYNC_POL(SYNC_POL)) u_hsync_edge (
        .clock       (clock),
        .reset       (reset),
        .sync_in     (vgaHsync),
        .assert_edge (h_edge)
    );

    vga_sync_edge_detect #(.SYNC_POL(SYNC_POL)) u_vsync_edge (
        .clock       (clock),
        .reset       (reset),
        .sync_in     (vgaVsync),
        .assert_edge (v_edge)
    );

    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic [9:0]       hcnt_q, hcnt_d;
    logic [9:0]       vcnt_q, vcnt_d;
    cap_state_e       state_q, state_d;
    logic [2:0]       good_q, good_d;
    logic             pix_valid_q, pix_valid_d;
    logic [9:0]       pix_x_q, pix_x_d;
    logic [8:0]       pix_y_q, pix_y_d;
    logic [RGB_W-1:0] pix_data_q, pix_data_d;
    logic             frame_start_q, frame_start_d;
    logic             locked_q, locked_d;
    logic             lock_err_q, lock_err_d;
    logic             line_bad, frame_bad, in_window;

    always_comb begin
        rgb_d = vgaRGB;

        hcnt_d = hcnt_q;
        if (h_edge)
            hcnt_d = '0;
        else if (hcnt_q != '1)
            hcnt_d = hcnt_q + 10'd1;

        // a coincident hsync edge is not counted into the new frame
        vcnt_d = vcnt_q;
        if (v_edge)
            vcnt_d = '0;
        else if (h_edge && vcnt_q != '1)
            vcnt_d = vcnt_q + 10'd1;

        line_bad  = h_edge && (({1'b0, hcnt_q} + 11'd1) != H_TOTAL_L);
        // the coincident hsync edge closes the last line of the frame being judged
        frame_bad = ({1'b0, vcnt_q} + {10'd0, h_edge}) != V_TOTAL_L;

        state_d    = state_q;
        good_d     = good_q;
        lock_err_d = 1'b0;
        case (state_q)
            SEARCH: begin
                if (v_edge) begin
                    state_d = MEASURE;
                    good_d  = '0;
                end
            end
            MEASURE: begin
                if (v_edge) begin
                    if (line_bad || frame_bad) begin
                        good_d = '0;
                    end else begin
                        good_d = good_q + 3'd1;
                        if (good_q + 3'd1 == LOCK_L)
                            state_d = LOCKED;
                    end
                end else if (line_bad) begin
                    good_d = '0;
                end
            end
            LOCKED: begin
                if (line_bad || (v_edge && frame_bad)) begin
                    state_d    = SEARCH;
                    lock_err_d = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase

        // hcnt_d/vcnt_d are the position of the pixel currently held in rgb_q
        in_window = ({1'b0, hcnt_d} >= H_BEG_L) && ({1'b0, hcnt_d} < H_END_L) &&
                    ({1'b0, vcnt_d} >= V_BEG_L) && ({1'b0, vcnt_d} < V_END_L);

        pix_valid_d   = (state_q == LOCKED) && !lock_err_d && in_window;
        pix_x_d       = pix_valid_d ? (hcnt_d - H_OFS) : pix_x_q;
        pix_y_d       = pix_valid_d ? (vcnt_d[8:0] - V_OFS) : pix_y_q;
        pix_data_d    = pix_valid_d ? rgb_q : pix_data_q;
        frame_start_d = v_edge && (state_q == LOCKED) && !lock_err_d;
        locked_d      = (state_d == LOCKED);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rgb_q         <= '0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            state_q       <= SEARCH;
            good_q        <= '0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_data_q    <= '0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            lock_err_q    <= 1'b0;
        end else begin
            rgb_q         <= rgb_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            state_q       <= state_d;
            good_q        <= good_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_data_q    <= pix_data_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            lock_err_q    <= lock_err_d;
        end
    end

    assign pixValid   = pix_valid_q;
    assign pixX       = pix_x_q;
    assign pixY       = pix_y_q;
    assign pixData    = pix_data_q;
    assign frameStart = frame_start_q;
    assign locked     = locked_q;
    assign lockErr    = lock_err_q;

`ifdef VGA_CAPTURE_CRC_EN
    logic [15:0] crc_q, crc_d;
    logic [15:0] frame_crc_q, frame_crc_d;
    logic        crc_valid_q, crc_valid_d;

    // the running CRC only accumulates within an unbroken locked frame
    always_comb begin
        crc_d       = crc_q;
        frame_crc_d = frame_crc_q;
        crc_valid_d = 1'b0;
        if (frame_start_d) begin
            frame_crc_d = crc_q;
            crc_valid_d = 1'b1;
            crc_d       = 16'hFFFF;
        end else if (state_q != LOCKED) begin
            crc_d = 16'hFFFF;
        end else if (pix_valid_d) begin
            crc_d = crc16_step_pix(crc_q, rgb_q);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            crc_q       <= 16'hFFFF;
            frame_crc_q <= '0;
            crc_valid_q <= 1'b0;
        end else begin
            crc_q       <= crc_d;
            frame_crc_q <= frame_crc_d;
            crc_valid_q <= crc_valid_d;
        end
    end

    assign frameCrc = frame_crc_q;
    assign crcValid = crc_valid_q;
`endif

endmodule

// File: tb/tb_vga_capture_receiver.sv
// Randomised stream bench for vga_capture_receiver on a reduced 40x20 mode, checked every
// cycle against a frame/line-level reference model; CRC checks need VGA_CAPTURE_CRC_EN.
module tb_vga_capture_receiver;

    localparam int HT = 40, VT = 20, HB = 8, VB = 4, HA = 24, VA = 12;
    localparam int HSW = 4, VSW = 2, LOCKF = 2;
    localparam int NFR = 11, ERR_F = 5, ERR_L = 6;
    localparam int MAXE = 16384;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       hs = 1'b1, vs = 1'b1;
    logic [8:0] rgb = '0;
    logic       pixValid, frameStart, locked, lockErr;
    logic [9:0] pixX;
    logic [8:0] pixY, pixData;
`ifdef VGA_CAPTURE_CRC_EN
    logic [15:0] frameCrc;
    logic        crcValid;
`endif

    vga_capture_receiver #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_BACK(HB), .V_BACK(VB),
        .H_ACTIVE(HA), .V_ACTIVE(VA), .SYNC_POL(1'b0), .LOCK_FRAMES(LOCKF)
    ) dut (
        .clock(clock), .reset(reset), .vgaHsync(hs), .vgaVsync(vs), .vgaRGB(rgb),
        .pixValid(pixValid), .pixX(pixX), .pixY(pixY), .pixData(pixData),
        .frameStart(frameStart), .locked(locked), .lockErr(lockErr)
`ifdef VGA_CAPTURE_CRC_EN
        , .frameCrc(frameCrc), .crcValid(crcValid)
`endif
    );

    always #5 clock = ~clock;

    int edge_cnt = 0;
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    int checks = 0, passed = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_cnt);
    endtask

    // expected outputs indexed by the clock edge after which they must be visible
    bit        e_valid [MAXE];
    bit        e_locked[MAXE];
    bit        e_err   [MAXE];
    bit        e_fs    [MAXE];
    bit [9:0]  e_x     [MAXE];
    bit [8:0]  e_y     [MAXE];
    bit [8:0]  e_d     [MAXE];
    bit        e_crcv  [MAXE];
    bit [15:0] e_crc   [MAXE];

    int stop_m = MAXE - 4;
    int exp_pix_n = 0, exp_fs_n = 0, exp_crc_n = 0;

    // lock is held from the (LOCKF+1)th clean vsync edge, counted from reset and from the error
    function automatic bit frame_locked(input int f);
        return (f >= LOCKF && f <= ERR_F) || (f >= ERR_F + LOCKF + 1);
    endfunction

    function automatic bit [15:0] ref_crc(input bit [15:0] c, input bit [8:0] d);
        int r;
        r = int'(c) ^ (int'(d) << 7);
        for (int i = 0; i < 9; i++)
            r = ((r & 'h8000) != 0) ? (((r << 1) ^ 'h1021) & 'hFFFF) : ((r << 1) & 'hFFFF);
        return r[15:0];
    endfunction

    initial begin
        int        k, m, len;
        bit        live, act, prev_full;
        bit [8:0]  data;
        bit [15:0] mcrc;
        prev_full = 1'b0;
        mcrc      = 16'hFFFF;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int f = 0; f < NFR; f++) begin
            for (int l = 0; l < VT; l++) begin
                len = (f == ERR_F && l == ERR_L) ? HT - 1 : HT;
                for (int c = 0; c < len; c++) begin
                    k = edge_cnt;
                    m = k + 2;
                    if (f == 2)                data = 9'(c - HB);
                    else if (f == 3 || f == 4) data = 9'd0;
                    else                       data = 9'($urandom_range(0, 511));
                    hs  = (c < HSW) ? 1'b0 : 1'b1;
                    vs  = (l < VSW) ? 1'b0 : 1'b1;
                    rgb = data;
                    live = frame_locked(f) && !(f == ERR_F && l > ERR_L);
                    act  = live && c >= HB && c < HB + HA && l >= VB && l < VB + VA;
                    e_locked[m] = live;
                    e_err[m]    = (f == ERR_F && l == ERR_L + 1 && c == 0);
                    e_valid[m]  = act;
                    if (l == 0 && c == 0) begin
                        e_fs[m]   = prev_full;
                        e_crcv[m] = prev_full;
                        if (prev_full) begin
                            e_crc[m] = mcrc;
                            exp_fs_n++;
                            exp_crc_n++;
                        end
                        mcrc      = 16'hFFFF;
                        prev_full = frame_locked(f) && f != ERR_F;
                    end
                    if (act) begin
                        e_x[m] = 10'(c - HB);
                        e_y[m] = 9'(l - VB);
                        e_d[m] = data;
                        mcrc   = ref_crc(mcrc, data);
                        exp_pix_n++;
                    end
                    @(posedge clock);
                    #1;
                end
            end
        end
        stop_m = edge_cnt + 1;
        hs = 1'b1;
        vs = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        final_checks();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    int        pix_n = 0, fs_n = 0, err_n = 0;
    bit [9:0]  hold_x = '0;
    bit [8:0]  hold_y = '0, hold_d = '0;
    bit [15:0] hold_crc = '0;
    logic [15:0] crc_seen[$];

    always @(negedge clock) begin
        int m;
        m = edge_cnt;
        if (m > 0 && m <= stop_m) begin
            check_val("locked", 32'(locked), 32'(e_locked[m]));
            check_val("lock_err", 32'(lockErr), 32'(e_err[m]));
            check_val("frame_start", 32'(frameStart), 32'(e_fs[m]));
            check_val("pix_valid", 32'(pixValid), 32'(e_valid[m]));
            if (e_valid[m]) begin
                hold_x = e_x[m];
                hold_y = e_y[m];
                hold_d = e_d[m];
            end
            check_val("pix_xy_data", {4'd0, pixX, pixY, pixData}, {4'd0, hold_x, hold_y, hold_d});
            if (pixValid === 1'b1) pix_n++;
            if (frameStart === 1'b1) fs_n++;
            if (lockErr === 1'b1) err_n++;
`ifdef VGA_CAPTURE_CRC_EN
            check_val("crc_valid", 32'(crcValid), 32'(e_crcv[m]));
            if (e_crcv[m]) hold_crc = e_crc[m];
            check_val("frame_crc", 32'(frameCrc), 32'(hold_crc));
            if (crcValid === 1'b1) crc_seen.push_back(frameCrc);
`endif
        end
    end

    task automatic final_checks();
        check_val("pix_count", 32'(pix_n), 32'(exp_pix_n));
        check_val("frame_start_count", 32'(fs_n), 32'(exp_fs_n));
        check_val("lock_err_count", 32'(err_n), 32'd1);
`ifdef VGA_CAPTURE_CRC_EN
        check_val("crc_pulse_count", 32'(crc_seen.size()), 32'(exp_crc_n));
        // frames 3 and 4 carry all-zero RGB, so their CRCs (pulses 2 and 3) must agree
        if (crc_seen.size() >= 3)
            check_val("crc_repeat", 32'(crc_seen[2]), 32'(crc_seen[1]));
`endif
    endtask

endmodule
